// File: rtl/burst_ram_pkg.sv
// Shared encodings for the burst RAM model and the cache side that drives it.
package burst_ram_pkg;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

  typedef enum logic [4:0] {
    IDLE        = 5'b00001,
    READ_WAIT   = 5'b00010,
    READ_BURST  = 5'b00100,
    WRITE_BURST = 5'b01000,
    REFRESH     = 5'b10000
  } br_state_e;

endpackage

// File: rtl/burst_ram_refresh_timer.sv
// Free-running refresh interval counter with a single pending-request flag.
// Only instantiated when BURST_RAM_REFRESH_EN is defined.
module burst_ram_refresh_timer #(
  parameter int unsigned INTERVAL = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serve_i,
  output logic pending_o
);

  localparam int unsigned CNT_W = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             tick_c;

  assign tick_c = (cnt_q == CNT_W'(INTERVAL - 1));

  // A new tick re-arms the flag even while an older request is being served.
  always_comb begin
    cnt_d     = tick_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    pending_d = (pending_q & ~serve_i) | tick_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/burst_ram_model.sv
// Cycle-accurate burst RAM: fixed-length read/write bursts with wrap-around
// addressing and a busy flag. Optional refresh under BURST_RAM_REFRESH_EN.
module burst_ram_model
  import burst_ram_pkg::*;
#(
  parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
  parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
  parameter int unsigned RAM_BURST_DATA_COUNT    = 4,
  parameter int unsigned READ_LATENCY            = 2,
  parameter int unsigned REFRESH_INTERVAL        = 64,
  parameter int unsigned REFRESH_CYCLES          = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 br_cmd,
  input  logic                                 br_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  output logic                                 br_rd_data_valid,
  output logic                                 br_busy
);

  localparam int unsigned AW     = RAM_DEPTH_BITWIDTH;
  localparam int unsigned DW     = RAM_BURST_DATA_BITWIDTH;
  localparam int unsigned MASK_W = DW / 8;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned BEAT_W = (RAM_BURST_DATA_COUNT > 2) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam int unsigned LAT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned LAT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  if (RAM_BURST_DATA_COUNT < 2 || READ_LATENCY < 1 || (DW % 8) != 0 ||
      REFRESH_INTERVAL < 2 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("burst_ram_model: illegal parameter combination");
  end

  br_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [AW-1:0]     addr_q, addr_d;

  logic [DW-1:0]     mem_q [DEPTH];
  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [AW-1:0]     beat_addr_c;
  logic              cmd_accept_c;
  logic              last_beat_c;

`ifdef BURST_RAM_REFRESH_EN
  localparam int unsigned REF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             refresh_pending;
  logic             refresh_serve_c;

  burst_ram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk       (clk),
    .rst_n     (rst),
    .serve_i   (refresh_serve_c),
    .pending_o (refresh_pending)
  );
`endif

  // Beat k of the burst lives at (base + k) mod depth.
  assign beat_addr_c  = addr_q + AW'(beat_q);
  assign last_beat_c  = (beat_q == BEAT_W'(RAM_BURST_DATA_COUNT - 1));
  assign cmd_accept_c = br_cmd_en & ~busy_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    rd_data_d   = rd_data_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = beat_addr_c;
`ifdef BURST_RAM_REFRESH_EN
    ref_cnt_d       = ref_cnt_q;
    refresh_serve_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        beat_d = '0;
        lat_d  = '0;
        if (cmd_accept_c) begin
          addr_d = br_addr;
          busy_d = 1'b1;
          if (br_cmd == BR_CMD_WRITE) begin
            // Beat 0 commits on the accepting edge itself.
            mem_we_c    = 1'b1;
            mem_waddr_c = br_addr;
            beat_d      = BEAT_W'(1);
            state_d     = WRITE_BURST;
          end else begin
            state_d = (READ_LATENCY == 1) ? READ_BURST : READ_WAIT;
          end
        end
`ifdef BURST_RAM_REFRESH_EN
        else if (refresh_pending) begin
          busy_d          = 1'b1;
          ref_cnt_d       = '0;
          refresh_serve_c = 1'b1;
          state_d         = REFRESH;
        end
`endif
      end
      WRITE_BURST: begin
        mem_we_c = 1'b1;
        if (last_beat_c) begin
          beat_d  = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          beat_d = BEAT_W'(beat_q + BEAT_W'(1));
        end
      end
      READ_WAIT: begin
        if (lat_q == LAT_W'(LAT_LAST)) begin
          state_d = READ_BURST;
        end else begin
          lat_d = LAT_W'(lat_q + LAT_W'(1));
        end
      end
      READ_BURST: begin
        valid_d   = 1'b1;
        rd_data_d = mem_q[beat_addr_c];
        // Busy stays high through the last beat; IDLE drops it one cycle later.
        if (last_beat_c) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = BEAT_W'(beat_q + BEAT_W'(1));
        end
      end
`ifdef BURST_RAM_REFRESH_EN
      REFRESH: begin
        if (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ref_cnt_d = REF_W'(ref_cnt_q + REF_W'(1));
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
`ifdef BURST_RAM_REFRESH_EN
      ref_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
`ifdef BURST_RAM_REFRESH_EN
      ref_cnt_q <= ref_cnt_d;
`endif
    end
  end

  // Storage is not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!br_data_mask[b]) begin
          mem_q[mem_waddr_c][b*8 +: 8] <= br_wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign br_rd_data       = rd_data_q;
  assign br_rd_data_valid = valid_q;
  assign br_busy          = busy_q;

endmodule
